// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//  Timing constants for the 640x480 @ 60 Hz raster. It also holds the derived
//  line/frame totals, the first visible coordinate and the coordinate type
//  shared by the timing generator and its counters.
//  Ports: none (package).
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;

    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;

    localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // The counters start at the beginning of sync, so the renderer offsets
    // its objects by these amounts.
    localparam int H_START  = H_SYNC + H_BP;
    localparam int V_START  = V_SYNC + V_BP;

endpackage

// File: rtl/vga_counter.sv
// ---------------------------------------------------------------------------
// vga_counter
//  Mod-N up counter with enable, synchronous reset and a wrap pulse.
//  Ports:
//   clk_i    in   clock
//   reset_i  in   synchronous active-high reset, count returns to 0
//   en_i     in   advance the count on this edge
//   count_o  out  current count, 0..N-1
//   wrap_o   out  high while enabled at N-1, i.e. the next edge returns to 0
// ---------------------------------------------------------------------------
module vga_counter
    import vga_pkg::*;
#(
    parameter int N = 800
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   en_i,
    output coord_t count_o,
    output logic   wrap_o
);

    localparam coord_t LAST = coord_t'(N - 1);

    coord_t count_q;
    coord_t count_d;

    // The wrap pulse is combinational so that a cascaded counter can advance
    // on the same edge as this one returns to zero.
    assign wrap_o  = en_i && (count_q == LAST);
    assign count_o = count_q;

    // Next count: hold unless enabled, then increment or fold back to zero.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//  Raster timing generator. It divides CLOCK_50 into a 25 MHz pixel cadence,
//  runs the raw X/Y counters from the start of sync, and registers sync,
//  blank and vblank one cycle behind the counters. VGA_CLK is placed so its
//  rising edge sits midway between output updates.
//  Ports:
//   CLOCK_50     in   system clock, 50 MHz
//   reset        in   synchronous active-high reset
//   VGA_X/VGA_Y  out  raw horizontal / vertical counters
//   VGA_HS/VS    out  active-low syncs (registered)
//   VGA_BLANK_N  out  high during active video (registered)
//   VGA_SYNC_N   out  constant 0
//   VGA_CLK      out  25 MHz DAC sample clock
//   pixel_tick   out  high every second cycle; counters move on the next edge
//   frame_start  out  one-cycle pulse after the counters wrap to (0,0)
//   in_vblank    out  high on the lines below the visible area
// ---------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP
) (
    input  logic   CLOCK_50,
    input  logic   reset,
    output coord_t VGA_X,
    output coord_t VGA_Y,
    output logic   VGA_HS,
    output logic   VGA_VS,
    output logic   VGA_BLANK_N,
    output logic   VGA_SYNC_N,
    output logic   VGA_CLK,
    output logic   pixel_tick,
    output logic   frame_start,
    output logic   in_vblank
);

    localparam int LINE_LEN  = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int FRAME_LEN = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam coord_t HS_END = coord_t'(H_SYNC);
    localparam coord_t VS_END = coord_t'(V_SYNC);
    localparam coord_t HA_BEG = coord_t'(H_SYNC + H_BP);
    localparam coord_t HA_END = coord_t'(H_SYNC + H_BP + H_ACTIVE);
    localparam coord_t VA_BEG = coord_t'(V_SYNC + V_BP);
    localparam coord_t VA_END = coord_t'(V_SYNC + V_BP + V_ACTIVE);

    // Totals beyond the coordinate range would silently alias.
    if (LINE_LEN > (1 << COORD_W) || FRAME_LEN > (1 << COORD_W)) begin : g_range_check
        $error("vga_timing: line or frame total exceeds the 10-bit coordinate range");
    end

    logic   phase_q, phase_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;
    logic   blankN_q, blankN_d;
    logic   inVblank_q, inVblank_d;
    logic   frameStart_q, frameStart_d;
    logic   vgaClk_q, vgaClk_d;

    logic   tick;
    logic   hWrap;
    logic   vWrap;
    coord_t hCount;
    coord_t vCount;

    assign tick = phase_q;

    vga_counter #(.N(LINE_LEN)) u_hcount (
        .clk_i   (CLOCK_50),
        .reset_i (reset),
        .en_i    (tick),
        .count_o (hCount),
        .wrap_o  (hWrap)
    );

    vga_counter #(.N(FRAME_LEN)) u_vcount (
        .clk_i   (CLOCK_50),
        .reset_i (reset),
        .en_i    (tick && hWrap),
        .count_o (vCount),
        .wrap_o  (vWrap)
    );

    // Output decode from the current counters. Registering it delays the
    // syncs by one cycle so they line up with the renderer's RGB register.
    // VGA_CLK copies the old phase, so it equals ~phase and rises between updates.
    always_comb begin
        phase_d      = ~phase_q;
        hs_d         = !(hCount < HS_END);
        vs_d         = !(vCount < VS_END);
        blankN_d     = (hCount >= HA_BEG) && (hCount < HA_END) &&
                       (vCount >= VA_BEG) && (vCount < VA_END);
        inVblank_d   = (vCount >= VA_END);
        frameStart_d = vWrap;
        vgaClk_d     = phase_q;
    end

    // Phase and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            phase_q      <= 1'b0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            blankN_q     <= 1'b0;
            inVblank_q   <= 1'b0;
            frameStart_q <= 1'b0;
            vgaClk_q     <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            blankN_q     <= blankN_d;
            inVblank_q   <= inVblank_d;
            frameStart_q <= frameStart_d;
            vgaClk_q     <= vgaClk_d;
        end
    end

    assign VGA_X       = hCount;
    assign VGA_Y       = vCount;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blankN_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vgaClk_q;
    assign pixel_tick  = tick;
    assign frame_start = frameStart_q;
    assign in_vblank   = inVblank_q;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//  Bench for vga_timing. One instance uses the real 640x480 timing. A second
//  instance uses a tiny raster so whole frames fit in a short run. Expected
//  outputs come from a closed-form function of the number of edges since
//  reset and are queued on each edge and compared on the following negedge.
//  Directed measurements cover line, sync and frame properties.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blankN;
        logic       syncN;
        logic       vgaClk;
        logic       tick;
        logic       frameStart;
        logic       inVblank;
    } outs_t;

    localparam int S_HS = 4, S_HB = 3, S_HA = 8, S_HF = 2;
    localparam int S_VS = 2, S_VB = 2, S_VA = 4, S_VF = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [9:0] vgaX, vgaY, smX, smY;
    logic hs, vs, blankN, syncN, vgaClk, tick, frameStart, inVblank;
    logic smHs, smVs, smBlankN, smSyncN, smVgaClk, smTick, smFrameStart, smInVblank;

    int testsRun    = 0;
    int testsFailed = 0;
    int tCount      = 0;
    outs_t expQ[$];
    outs_t expSmQ[$];

    vga_timing dut (
        .CLOCK_50(clock), .reset(reset), .VGA_X(vgaX), .VGA_Y(vgaY),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blankN), .VGA_SYNC_N(syncN),
        .VGA_CLK(vgaClk), .pixel_tick(tick), .frame_start(frameStart),
        .in_vblank(inVblank)
    );

    vga_timing #(
        .H_SYNC(S_HS), .H_BP(S_HB), .H_ACTIVE(S_HA), .H_FP(S_HF),
        .V_SYNC(S_VS), .V_BP(S_VB), .V_ACTIVE(S_VA), .V_FP(S_VF)
    ) dutSmall (
        .CLOCK_50(clock), .reset(reset), .VGA_X(smX), .VGA_Y(smY),
        .VGA_HS(smHs), .VGA_VS(smVs), .VGA_BLANK_N(smBlankN), .VGA_SYNC_N(smSyncN),
        .VGA_CLK(smVgaClk), .pixel_tick(smTick), .frame_start(smFrameStart),
        .in_vblank(smInVblank)
    );

    // 50 MHz clock.
    initial forever #10 clock = ~clock;

    // Expected outputs after t edges since the last reset edge (t=0 is the
    // reset state). Pixels advance on every second edge; registered outputs
    // reflect the counters from one edge earlier.
    function automatic outs_t model(input int t, input int hSw, input int hBw,
                                    input int hAw, input int hFw, input int vSw,
                                    input int vBw, input int vAw, input int vFw);
        outs_t o;
        int ht, vt, p, pp, px, py;
        ht = hSw + hBw + hAw + hFw;
        vt = vSw + vBw + vAw + vFw;
        p  = t / 2;
        o  = '0;
        o.x = 10'(p % ht);
        o.y = 10'((p / ht) % vt);
        o.syncN = 1'b0;
        if (t == 0) begin
            o.hs = 1'b1;
            o.vs = 1'b1;
        end else begin
            pp = (t - 1) / 2;
            px = pp % ht;
            py = (pp / ht) % vt;
            o.hs         = (px >= hSw);
            o.vs         = (py >= vSw);
            o.blankN     = (px >= hSw + hBw) && (px < hSw + hBw + hAw) &&
                           (py >= vSw + vBw) && (py < vSw + vBw + vAw);
            o.inVblank   = (py >= vSw + vBw + vAw);
            o.tick       = (t % 2 == 1);
            o.vgaClk     = (t % 2 == 0);
            o.frameStart = (t % 2 == 0) && (p % (ht * vt) == 0);
        end
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input int cycles);
        reset = r;
        repeat (cycles) @(negedge clock);
    endtask

    // Scoreboard producer: on each edge queue what both instances must show.
    always @(posedge clock) begin
        if (reset) tCount <= 0;
        else       tCount <= tCount + 1;
        expQ.push_back(model(reset ? 0 : tCount + 1, 96, 48, 640, 16, 2, 33, 480, 10));
        expSmQ.push_back(model(reset ? 0 : tCount + 1, S_HS, S_HB, S_HA, S_HF,
                               S_VS, S_VB, S_VA, S_VF));
    end

    // Scoreboard consumer: compare away from the active edge.
    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            checkOutput("cycle", 32'({vgaX, vgaY, hs, vs, blankN, syncN, vgaClk,
                                      tick, frameStart, inVblank}),
                        32'(expQ.pop_front()));
        end
        if (expSmQ.size() > 0) begin
            checkOutput("cycleSmall", 32'({smX, smY, smHs, smVs, smBlankN, smSyncN,
                                           smVgaClk, smTick, smFrameStart, smInVblank}),
                        32'(expSmQ.pop_front()));
        end
    end

    initial begin
        int maxX, wrapT, yBefore, yAfter, hsLow, vsLow, vbHigh, blHigh;
        int hsFalls[$];
        int fsTimes[$];
        logic [9:0] prevX, prevY;
        logic prevHs;
        bit found;

        maxX = 0; wrapT = -1; yBefore = -1; yAfter = -1;
        hsLow = 0; vsLow = 0; vbHigh = 0; blHigh = 0;

        // Reset held for five edges.
        applyStimulus(1'b1, 5);
        checkOutput("resetState", 32'({vgaX, vgaY, hs, vs, blankN}),
                    32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
        prevX = vgaX; prevY = vgaY; prevHs = hs;

        // Three full lines of the real timing, many small frames.
        for (int t = 1; t <= 4800; t++) begin
            applyStimulus(1'b0, 1);
            if (t == 1) begin
                checkOutput("syncAfterRelease", 32'({hs, vs}), 32'(2'b00));
                checkOutput("firstTick", 32'(tick), 32'(1));
            end
            if (t == 2) checkOutput("tickGap", 32'(tick), 32'(0));
            if (int'(vgaX) > maxX) maxX = int'(vgaX);
            if (wrapT < 0 && prevX == 10'd799 && vgaX == 10'd0) begin
                wrapT = t; yBefore = int'(prevY); yAfter = int'(vgaY);
            end
            if (prevHs && !hs) hsFalls.push_back(t);
            if (!hs) hsLow++;
            if (smFrameStart) fsTimes.push_back(t);
            if (fsTimes.size() == 1) begin
                if (!smVs) vsLow++;
                if (smInVblank) vbHigh++;
                if (smBlankN) blHigh++;
            end
            prevX = vgaX; prevY = vgaY; prevHs = hs;
        end

        checkOutput("maxX", 32'(maxX), 32'(799));
        checkOutput("xWrapTime", 32'(wrapT), 32'(1600));
        checkOutput("yStep", 32'({yBefore[9:0], yAfter[9:0]}), 32'({10'd0, 10'd1}));
        checkOutput("hsFallCount", 32'(hsFalls.size()), 32'(3));
        checkOutput("hsPeriod", 32'(hsFalls.size() >= 2 ? hsFalls[1] - hsFalls[0] : -1), 32'(1600));
        checkOutput("hsAfterWrap", 32'(hsFalls.size() >= 2 ? hsFalls[1] - wrapT : -1), 32'(1));
        checkOutput("hsLowCycles", 32'(hsLow), 32'(576));
        checkOutput("frameCount", 32'(fsTimes.size()), 32'(12));
        checkOutput("framePeriod", 32'(fsTimes.size() >= 2 ? fsTimes[1] - fsTimes[0] : -1), 32'(374));
        checkOutput("vsLowCycles", 32'(vsLow), 32'(68));
        checkOutput("vblankCycles", 32'(vbHigh), 32'(102));
        checkOutput("blankHighCycles", 32'(blHigh), 32'(64));

        // Reset in the middle of a line, bounded search for the trigger point.
        found = 1'b0;
        for (int c = 0; c < 4000 && !found; c++) begin
            applyStimulus(1'b0, 1);
            if (vgaX == 10'd400 && vgaY == 10'd3) found = 1'b1;
        end
        checkOutput("midResetTrigger", 32'(found), 32'(1));
        applyStimulus(1'b1, 1);
        checkOutput("midResetState", 32'({vgaX, vgaY, hs, vs, blankN, tick, vgaClk}),
                    32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        for (int t = 1; t <= 1700; t++) begin
            applyStimulus(1'b0, 1);
            if (t == 1) checkOutput("restartSync", 32'({hs, vs, tick}), 32'(3'b001));
            if (t == 1600) checkOutput("restartWrap", 32'({vgaX, vgaY}), 32'({10'd0, 10'd1}));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
